// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the single-clock FIFO.
package fifo_pkg;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Push/pop bus and status flags of the single-clock FIFO.
interface sync_fifo_ctrl_if import fifo_pkg::*; #(
    parameter int Width = 8,
    parameter int Depth = 8
);
    localparam int CW = cnt_w(Depth);

    logic             clear_i;
    logic             write_i;
    logic [Width-1:0] w_data_i;
    logic             read_i;
    logic [Width-1:0] r_data_o;
    logic             r_valid_o;
    logic [CW-1:0]    count_o;
    logic             full_flag_o;
    logic             empty_flag_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output clear_i, write_i, w_data_i, read_i,
        input  r_data_o, r_valid_o, count_o,
        input  full_flag_o, empty_flag_o,
        input  almost_full_o, almost_empty_o,
        input  overflow_o, underflow_o
    );

    modport slave (
        input  clear_i, write_i, w_data_i, read_i,
        output r_data_o, r_valid_o, count_o,
        output full_flag_o, empty_flag_o,
        output almost_full_o, almost_empty_o,
        output overflow_o, underflow_o
    );

endinterface

// File: rtl/fifo_mem.sv
// Depth x Width register array: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int Width = 8,
    parameter int Depth = 8,
    parameter int PW    = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [PW-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, flags, sticky errors.
module sync_fifo_ctrl import fifo_pkg::*; #(
    parameter int Width       = 8,
    parameter int Depth       = 8,
    parameter int AlmostFull  = 6,
    parameter int AlmostEmpty = 1,
    parameter bit Fwft        = 1'b0
) (
    input logic             clk_i,
    input logic             rst_i,
    sync_fifo_ctrl_if.slave bus
);

    localparam int PW = ptr_w(Depth);
    localparam int CW = cnt_w(Depth);
    localparam fifo_mode_e Mode = Fwft ? FWFT : STD;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [Width-1:0] rdata_q, rdata_d;
    logic [Width-1:0] mem_rdata;
    logic             rvalid_q, rvalid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full, empty, rd_acc, wr_acc;

    function automatic logic [PW-1:0] incr(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (count_q == CW'(Depth));
    assign empty  = (count_q == '0);
    assign rd_acc = bus.read_i & ~empty;
    assign wr_acc = bus.write_i & (~full | rd_acc);

    fifo_mem #(
        .Width (Width),
        .Depth (Depth),
        .PW    (PW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_acc & ~bus.clear_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.w_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (bus.clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = incr(wr_ptr_q);
            if (rd_acc) begin
                rd_ptr_d = incr(rd_ptr_q);
                rdata_d  = mem_rdata;
                rvalid_d = 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // a pop in the same cycle frees the slot, so that push is legal
            if (bus.write_i & full & ~rd_acc) ovf_d = 1'b1;
            if (bus.read_i & empty) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // FWFT masks the unreset memory so an empty FIFO shows zero
    assign bus.r_data_o = (Mode == FWFT) ? (empty ? '0 : mem_rdata)
                                         : rdata_q;
    assign bus.r_valid_o      = (Mode == FWFT) ? ~empty : rvalid_q;
    assign bus.count_o        = count_q;
    assign bus.full_flag_o    = full;
    assign bus.empty_flag_o   = empty;
    assign bus.almost_full_o  = (count_q >= CW'(AlmostFull));
    assign bus.almost_empty_o = (count_q <= CW'(AlmostEmpty));
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = unf_q;

endmodule
